alu_issue_unit: RTL

//  Receiving end of the issue-queue -> ALU interface: one per ALU slot (ALU0..2).

---
 rtl/uiq_pkg.sv | 57 +++++
 rtl/alu_issue_unit_if.sv | 50 +++++
 rtl/alu_result_fifo.sv | 62 ++++++
 rtl/alu_issue_unit.sv | 130 +++++++++++++
 4 files changed

// File: rtl/uiq_pkg.sv
// Shared definitions for the issue-queue -> ALU slice: optype codes, field
// widths, the issue-unit FSM state type and the ALU datapath function.
package uiq_pkg;

  localparam int OPTYPE_W = 4;
  localparam int PREG_W   = 6;
  localparam int XLEN     = 32;

  localparam logic [OPTYPE_W-1:0] OP_ADD  = 4'd1;
  localparam logic [OPTYPE_W-1:0] OP_ADDI = 4'd2;
  localparam logic [OPTYPE_W-1:0] OP_LUI  = 4'd3;
  localparam logic [OPTYPE_W-1:0] OP_ORI  = 4'd4;
  localparam logic [OPTYPE_W-1:0] OP_XOR  = 4'd5;
  localparam logic [OPTYPE_W-1:0] OP_SRAI = 4'd6;
  localparam logic [OPTYPE_W-1:0] OP_LB   = 4'd7;
  localparam logic [OPTYPE_W-1:0] OP_LW   = 4'd8;
  localparam logic [OPTYPE_W-1:0] OP_SB   = 4'd9;
  localparam logic [OPTYPE_W-1:0] OP_SW   = 4'd10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } alu_state_e;

  // Codes 1..10 are executable; 0 and 11..15 are dropped at issue.
  function automatic logic is_legal_op(input logic [OPTYPE_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_SW);
  endfunction

  function automatic logic is_store_op(input logic [OPTYPE_W-1:0] op);
    return (op == OP_SB) || (op == OP_SW);
  endfunction

  // Single-cycle ALU: 32-bit wrap-around, no flags. Memory ops produce the
  // effective address s1 + imm.
  function automatic logic [XLEN-1:0] alu_compute(
    input logic [OPTYPE_W-1:0] op,
    input logic [XLEN-1:0]     s1,
    input logic [XLEN-1:0]     s2,
    input logic [XLEN-1:0]     imm
  );
    logic [XLEN-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = s1 + s2;
      OP_ADDI: r = s1 + imm;
      OP_LUI:  r = imm;
      OP_ORI:  r = s1 | imm;
      OP_XOR:  r = s1 ^ s2;
      OP_SRAI: r = $unsigned($signed(s1) >>> imm[4:0]);
      OP_LB, OP_LW, OP_SB, OP_SW: r = s1 + imm;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_issue_unit_if.sv
// Issue-queue <-> ALU slot bundle: issue fields, FU_ready back-pressure and
// the writeback head/grant pair.
//
// Handshake rules:
//   issue: issue_valid_in is a one-cycle strobe; the op is taken on a rising
//          clock edge only when FU_ready_out is 1 in that cycle, otherwise
//          it is lost (the issue queue must re-issue).
//   wb:    wb_valid_out/wb_* stay stable until a cycle with wb_grant_in=1;
//          that edge pops the head. wb_grant_in with wb_valid_out=0 is a no-op.
interface alu_issue_unit_if
  import uiq_pkg::*;
#(
  parameter int ROB_W = 16
);
  logic                issue_valid_in;
  logic [31:0]         PC_in;
  logic [OPTYPE_W-1:0] optype_in;
  logic [31:0]         srcReg1_data_in;
  logic [31:0]         srcReg2_data_in;
  logic [31:0]         imm_in;
  logic [PREG_W-1:0]   destReg_in;
  logic [ROB_W-1:0]    ROBNum_in;
  logic                FU_ready_out;

  logic                wb_valid_out;
  logic                wb_grant_in;
  logic [31:0]         wb_result_out;
  logic [31:0]         wb_store_data_out;
  logic [OPTYPE_W-1:0] wb_optype_out;
  logic [PREG_W-1:0]   wb_destReg_out;
  logic [ROB_W-1:0]    wb_ROBNum_out;
  logic [31:0]         wb_PC_out;
  logic [1:0]          wb_aluNum_out;

  // Issue queue / writeback arbiter side
  modport master (
    output issue_valid_in, PC_in, optype_in, srcReg1_data_in, srcReg2_data_in,
           imm_in, destReg_in, ROBNum_in, wb_grant_in,
    input  FU_ready_out, wb_valid_out, wb_result_out, wb_store_data_out,
           wb_optype_out, wb_destReg_out, wb_ROBNum_out, wb_PC_out, wb_aluNum_out
  );

  // ALU slot side
  modport slave (
    input  issue_valid_in, PC_in, optype_in, srcReg1_data_in, srcReg2_data_in,
           imm_in, destReg_in, ROBNum_in, wb_grant_in,
    output FU_ready_out, wb_valid_out, wb_result_out, wb_store_data_out,
           wb_optype_out, wb_destReg_out, wb_ROBNum_out, wb_PC_out, wb_aluNum_out
  );
endinterface

// File: rtl/alu_result_fifo.sv
// Small show-ahead FIFO for completed ALU results. The head entry is visible
// on head_data whenever head_valid=1 and reads as all-zero when empty.
module alu_result_fifo #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         head_valid,
  output logic         full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             pop_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A pop request against an empty FIFO is dropped.
  assign pop_en     = pop && (count != '0);
  assign head_valid = (count != '0);
  assign full       = (count == CNT_W'(DEPTH));
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

  // Storage write; contents are don't-care while empty, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop both apply.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (pop_en) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  // The issue unit only accepts an op when a slot is free, so a push into a
  // full FIFO indicates a broken accept condition upstream.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(push && full));
`endif

endmodule

// File: rtl/alu_issue_unit.sv
// ALU slot issue unit: accepts one op from the issue queue, executes it for
// EXEC_LAT cycles, and buffers the result until writeback is granted.
// Build option: ALU_SKID_EN gives a 2-entry result queue so a new op can be
// accepted while one result waits for grant; otherwise the queue holds one.
module alu_issue_unit
  import uiq_pkg::*;
#(
  parameter logic [1:0] ALU_ID   = 2'd0,
  parameter int         ROB_W    = 16,
  parameter int         EXEC_LAT = 1
) (
  input  logic             clk,
  input  logic             rstn,
  alu_issue_unit_if.slave  bus,
  output alu_state_e       state_dbg
);
`ifdef ALU_SKID_EN
  localparam int QDEPTH = 2;
`else
  localparam int QDEPTH = 1;
`endif
  localparam int CNT_W   = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;
  localparam int ENTRY_W = 32 + 32 + OPTYPE_W + PREG_W + ROB_W + 32;

  alu_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                accept, push, fu_ready;
  logic                q_full, q_valid, q_pop;
  logic [ENTRY_W-1:0]  push_entry, head_entry;

  logic [OPTYPE_W-1:0] op_q;
  logic [31:0]         s1_q, s2_q, imm_q, pc_q;
  logic [PREG_W-1:0]   dest_q;
  logic [ROB_W-1:0]    rob_q;
  logic [31:0]         result, store_data;

  // Ready is decoded from registered state only, never from issue_valid_in.
  assign fu_ready = (state_q == ST_IDLE) && !q_full;

  // Next-state and strobe decode: accept in IDLE, push on the last EXEC cycle.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.issue_valid_in && fu_ready && is_legal_op(bus.optype_in)) begin
          accept  = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register; reset mid-EXEC discards the in-flight op.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // EXEC cycle counter: loaded with EXEC_LAT-1 on accept, counts down to 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= CNT_W'(EXEC_LAT - 1);
    end else if ((state_q == ST_EXEC) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Operand/metadata capture at accept; held stable through EXEC.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_q   <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      imm_q  <= '0;
      pc_q   <= '0;
      dest_q <= '0;
      rob_q  <= '0;
    end else if (accept) begin
      op_q   <= bus.optype_in;
      s1_q   <= bus.srcReg1_data_in;
      s2_q   <= bus.srcReg2_data_in;
      imm_q  <= bus.imm_in;
      pc_q   <= bus.PC_in;
      dest_q <= bus.destReg_in;
      rob_q  <= bus.ROBNum_in;
    end
  end

  // Datapath: computed from latched operands, consumed on the push cycle.
  always_comb begin
    result     = alu_compute(op_q, s1_q, s2_q, imm_q);
    store_data = is_store_op(op_q) ? s2_q : '0;
  end

  assign push_entry = {result, store_data, op_q, dest_q, rob_q, pc_q};
  assign q_pop      = q_valid && bus.wb_grant_in;

  alu_result_fifo #(
    .DEPTH (QDEPTH),
    .W     (ENTRY_W)
  ) u_result_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .push       (push),
    .push_data  (push_entry),
    .pop        (q_pop),
    .head_data  (head_entry),
    .head_valid (q_valid),
    .full       (q_full)
  );

  assign {bus.wb_result_out, bus.wb_store_data_out, bus.wb_optype_out,
          bus.wb_destReg_out, bus.wb_ROBNum_out, bus.wb_PC_out} = head_entry;
  assign bus.wb_valid_out  = q_valid;
  assign bus.FU_ready_out  = fu_ready;
  assign bus.wb_aluNum_out = ALU_ID;
  assign state_dbg         = state_q;

endmodule
